// File: rtl/seqdet_pkg.sv
// Shared types and default constants for the push-button serial sampler and its consumers.
package seqdet_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ARM_PRESS,
      HELD,
      ARM_REL
   } state_t;

   // 20 ms of stable button level at a 50 MHz system clock.
   localparam int unsigned DEBOUNCE_CYCLES_DFLT = 1_000_000;
   localparam int unsigned CNT_W_DFLT           = 20;
   localparam int unsigned BITCNT_W_DFLT        = 8;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous level; reset value is selectable.
module sync2 #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   logic s1_q;
   logic s2_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= RESET_VAL;
         s2_q <= RESET_VAL;
      end else begin
         s1_q <= din;
         s2_q <= s1_q;
      end
   end

   assign dout = s2_q;

endmodule

// File: rtl/pb_serial_sampler.sv
// Synchronises and debounces an active-low push-button, capturing the slide switch once per
// clean press and presenting it as a single-cycle strobed serial bit.
module pb_serial_sampler
   import seqdet_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT,
   parameter int unsigned CNT_W           = CNT_W_DFLT,
   parameter int unsigned BITCNT_W        = BITCNT_W_DFLT
) (
   input  logic                FPGAclk,
   input  logic                startSeq,
   input  logic                clkPb,
   input  logic                SwitchIn,
   output logic                serIn,
   output logic                bitStrobe,
   output logic [BITCNT_W-1:0] bitCount,
   output logic                busy,
   output logic                ledBit
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic pb_s2;
   logic sw_s2;
   logic pressed;
   logic sw;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                serin_q, serin_d;
   logic                strobe_q, strobe_d;
   logic [BITCNT_W-1:0] bitcnt_q, bitcnt_d;
   logic                busy_q, busy_d;
   logic                fire;

   // Button idles high, so its synchroniser resets to "released".
   sync2 #(
      .RESET_VAL(1'b1)
   ) u_sync_pb (
      .clk  (FPGAclk),
      .rst_n(startSeq),
      .din  (clkPb),
      .dout (pb_s2)
   );

   sync2 #(
      .RESET_VAL(1'b0)
   ) u_sync_sw (
      .clk  (FPGAclk),
      .rst_n(startSeq),
      .din  (SwitchIn),
      .dout (sw_s2)
   );

   assign pressed = ~pb_s2;
   assign sw      = sw_s2;

   always_ff @(posedge FPGAclk or negedge startSeq) begin
      if (!startSeq) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         serin_q  <= 1'b0;
         strobe_q <= 1'b0;
         bitcnt_q <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         serin_q  <= serin_d;
         strobe_q <= strobe_d;
         bitcnt_q <= bitcnt_d;
         busy_q   <= busy_d;
      end
   end

   // Every state change clears the counter.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (pressed) begin
               state_d = ARM_PRESS;
            end
         end
         ARM_PRESS: begin
            if (!pressed) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = HELD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         HELD: begin
            cnt_d = '0;
            if (!pressed) begin
               state_d = ARM_REL;
            end
         end
         ARM_REL: begin
            if (pressed) begin
               state_d = HELD;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are computed for the next edge so they register alongside the state.
   always_comb begin
      fire     = (state_q == ARM_PRESS) && pressed && (cnt_q == CNT_LAST);
      strobe_d = fire;
      serin_d  = fire ? sw : serin_q;
      bitcnt_d = bitcnt_q;
      if (fire && !(&bitcnt_q)) begin
         bitcnt_d = bitcnt_q + BITCNT_W'(1);
      end
      busy_d = (state_d != IDLE);
   end

   assign serIn     = serin_q;
   assign ledBit    = serin_q;
   assign bitStrobe = strobe_q;
   assign bitCount  = bitcnt_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_pb_serial_sampler.sv
// Directed bench for pb_serial_sampler with a short debounce window.
module tb_pb_serial_sampler;
   import seqdet_pkg::*;

   localparam int unsigned DB  = 4;
   // Negedges from setting clkPb low to seeing bitStrobe (or busy falling on release).
   localparam int          LAT = DB + 3;

   logic       FPGAclk = 1'b0;
   logic       startSeq;
   logic       clkPb;
   logic       SwitchIn;
   logic       serIn;
   logic       bitStrobe;
   logic [7:0] bitCount;
   logic       busy;
   logic       ledBit;

   int   n_checks     = 0;
   int   n_fail       = 0;
   int   strobe_total = 0;
   int   consec       = 0;
   logic prev_strobe  = 1'b0;

   always #5 FPGAclk = ~FPGAclk;

   pb_serial_sampler #(
      .DEBOUNCE_CYCLES(DB),
      .CNT_W          (20),
      .BITCNT_W       (8)
   ) dut (
      .FPGAclk  (FPGAclk),
      .startSeq (startSeq),
      .clkPb    (clkPb),
      .SwitchIn (SwitchIn),
      .serIn    (serIn),
      .bitStrobe(bitStrobe),
      .bitCount (bitCount),
      .busy     (busy),
      .ledBit   (ledBit)
   );

   // Strobe monitor, sampled shortly after each rising edge.
   always begin
      @(posedge FPGAclk);
      #2;
      if (bitStrobe === 1'b1) begin
         strobe_total++;
         if (prev_strobe) consec++;
      end
      prev_strobe = (bitStrobe === 1'b1);
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge FPGAclk);
   endtask

   task automatic do_reset();
      clkPb    = 1'b1;
      SwitchIn = 1'b0;
      startSeq = 1'b0;
      step(3);
      startSeq = 1'b1;
      step(2);
   endtask

   task automatic wait_strobe(input int budget, output int lat);
      lat = -1;
      for (int i = 1; i <= budget; i++) begin
         @(negedge FPGAclk);
         if (bitStrobe === 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic wait_idle(input int budget, output int lat);
      lat = -1;
      for (int i = 1; i <= budget; i++) begin
         @(negedge FPGAclk);
         if (busy === 1'b0) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic press(input logic bit_v, output int lat);
      int rl;
      SwitchIn = bit_v;
      step(3);
      clkPb = 1'b0;
      wait_strobe(4 * LAT, lat);
      step(2);
      clkPb = 1'b1;
      wait_idle(4 * LAT, rl);
      step(1);
   endtask

   initial begin
      int         lat;
      int         s0;
      logic [3:0] seq;
      seq = 4'b1101;  // entered LSB first: 1,0,1,1

      // 1. Reset, then idle
      clkPb    = 1'b1;
      SwitchIn = 1'b0;
      startSeq = 1'b0;
      step(3);
      check("rst_serIn", serIn, 0);
      check("rst_bitStrobe", bitStrobe, 0);
      check("rst_bitCount", bitCount, 0);
      check("rst_busy", busy, 0);
      check("rst_ledBit", ledBit, 0);
      startSeq = 1'b1;
      s0 = strobe_total;
      step(50);
      check("idle_strobes", strobe_total - s0, 0);
      check("idle_busy", busy, 0);
      check("idle_bitCount", bitCount, 0);

      // 2. Clean press with SwitchIn=1, held 30 cycles
      SwitchIn = 1'b1;
      step(3);
      s0 = strobe_total;
      clkPb = 1'b0;
      wait_strobe(20, lat);
      check("clean_lat", lat, LAT);
      check("clean_serIn", serIn, 1);
      check("clean_ledBit", ledBit, 1);
      check("clean_bitCount", bitCount, 1);
      step(1);
      check("clean_strobe_one_cycle", bitStrobe, 0);
      step(22);
      check("clean_held_strobes", strobe_total - s0, 1);
      check("clean_held_busy", busy, 1);
      clkPb = 1'b1;
      wait_idle(20, lat);
      check("clean_release_lat", lat, LAT);

      // 3. Bouncy press, then held low
      do_reset();
      step(3);
      s0 = strobe_total;
      for (int i = 0; i < 8; i++) begin
         clkPb = (((i / 2) % 2) == 1);
         step(1);
      end
      clkPb = 1'b0;
      wait_strobe(20, lat);
      check("bounce_lat", lat, LAT);
      check("bounce_bitCount", bitCount, 1);
      check("bounce_serIn", serIn, 0);
      step(5);
      check("bounce_strobes", strobe_total - s0, 1);

      // 4. Release bounce 1,0,1 then stays released
      s0 = strobe_total;
      clkPb = 1'b1;
      step(1);
      clkPb = 1'b0;
      step(1);
      clkPb = 1'b1;
      wait_idle(20, lat);
      check("relbounce_busy_lat", lat, LAT);
      check("relbounce_strobes", strobe_total - s0, 0);
      check("relbounce_bitCount", bitCount, 1);

      // 5. Sequence 1,0,1,1
      do_reset();
      s0 = strobe_total;
      for (int i = 0; i < 4; i++) begin
         press(seq[i], lat);
         check($sformatf("seq_lat_%0d", i), lat, LAT);
         check($sformatf("seq_serIn_%0d", i), serIn, 32'(seq[i]));
      end
      check("seq_bitCount", bitCount, 4);
      check("seq_strobes", strobe_total - s0, 4);
      // Switch changes mid-debounce: value at the strobe edge wins
      SwitchIn = 1'b0;
      step(3);
      clkPb = 1'b0;
      step(2);
      SwitchIn = 1'b1;
      wait_strobe(20, lat);
      check("midsw_lat", lat, LAT - 2);
      check("midsw_serIn", serIn, 1);
      check("midsw_bitCount", bitCount, 5);
      SwitchIn = 1'b0;
      step(3);
      check("midsw_serIn_held", serIn, 1);
      clkPb = 1'b1;
      wait_idle(20, lat);
      step(1);

      // 6. Reset during ARM_PRESS at cnt=2, button still held at release
      do_reset();
      SwitchIn = 1'b1;
      step(3);
      s0 = strobe_total;
      clkPb = 1'b0;
      step(5);
      check("midrst_busy_before", busy, 1);
      startSeq = 1'b0;
      #1;
      check("midrst_busy_async", busy, 0);
      step(2);
      check("midrst_bitCount", bitCount, 0);
      check("midrst_strobes", strobe_total - s0, 0);
      startSeq = 1'b1;
      wait_strobe(20, lat);
      check("midrst_rearm_lat", lat, LAT);
      check("midrst_rearm_bitCount", bitCount, 1);
      step(2);
      clkPb = 1'b1;
      wait_idle(20, lat);
      step(1);

      // Saturation of bitCount
      do_reset();
      for (int i = 0; i < 255; i++) press(1'b1, lat);
      check("sat_reach_255", bitCount, 255);
      s0 = strobe_total;
      press(1'b0, lat);
      check("sat_lat", lat, LAT);
      check("sat_hold_255", bitCount, 255);
      check("sat_strobes", strobe_total - s0, 1);
      check("sat_serIn", serIn, 0);

      check("no_back_to_back_strobes", consec, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
